led_band_fc_sequencer: RTL

- Owns the LED-driver serial bus (SCLK, LAT) for one band while the function-control (FC) word is being programmed.
- Generates the FCWRTEN latch window (15 SCLK edges), the 48-bit FC shift window and the WRTFC latch window (5 SCLK edges) with exact edge counts.
- Sits between the HPS register interface, the grey-scale streamer and the FC setter. Claims the bus only when the streamer reports idle, then returns it to the streamer.

---
 rtl/led_band_pkg.sv | 29 ++
 rtl/led_band_sclk_gen.sv | 41 ++++
 rtl/led_band_fc_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/led_band_pkg.sv
// Shared types and window lengths for the LED band FC programming sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package led_band_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FCWRTEN = 2'd1,
    DATA    = 2'd2,
    WRTFC   = 2'd3
  } state_t;

  localparam int FC_WIDTH      = 48;
  localparam int FCWRTEN_EDGES = 15;
  localparam int FC_DATA_EDGES = FC_WIDTH;
  localparam int WRTFC_EDGES   = 5;
  localparam int EDGE_CNT_W    = 6;

  // Number of SCLK rising edges that make up the window of a given phase.
  function automatic logic [EDGE_CNT_W-1:0] phase_edges(input state_t s);
    case (s)
      FCWRTEN: phase_edges = EDGE_CNT_W'(FCWRTEN_EDGES);
      DATA:    phase_edges = EDGE_CNT_W'(FC_DATA_EDGES);
      WRTFC:   phase_edges = EDGE_CNT_W'(WRTFC_EDGES);
      default: phase_edges = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_band_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV cycles while enabled, SCLK starts low.
// Latency: first SCLK rise CLK_DIV cycles after enable; ticks are combinational one cycle ahead of SCLK.
// Backpressure: none; clear or disable forces the divider and SCLK back to zero.
module led_band_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic SCLK,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick      = enable && !clear && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_tick = tick && !SCLK;
  assign fall_tick = tick && SCLK;

  // Divider counter and SCLK toggle; idle or cleared means counter 0 and SCLK low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      SCLK    <= 1'b0;
    end else if (clear || !enable) begin
      div_cnt <= '0;
      SCLK    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      SCLK    <= ~SCLK;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_band_fc_sequencer.sv
// FC-word programming sequencer for one LED band: FCWRTEN (15), data (48), WRTFC (5) SCLK windows.
// Latency: busy rises the cycle after a request meets gs_idle; busy lasts 136*CLK_DIV cycles.
// Backpressure: requests coalesce into one pending flag until idle with gs_idle; gs_idle ignored once running.
module led_band_fc_sequencer
  import led_band_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hps_fc_write,
  input  logic gs_idle,
  output logic SCLK,
  output logic LAT,
  output logic fc_sel,
  output logic busy,
  output logic done
);

  state_t                  state, state_next;
  logic [EDGE_CNT_W-1:0]   edge_cnt, edge_cnt_next;
  logic                    lat_next, busy_next, fc_sel_next, done_next;
  logic                    pending, request, accept;
  logic                    rise_tick, fall_tick, phase_end;

  // A live request pulse counts immediately so acceptance lands on the following cycle.
  assign request   = pending | start | hps_fc_write;
  assign accept    = (state == IDLE) && request && gs_idle;
  // A phase closes on the falling tick after its last rising edge, keeping LAT away from SCLK rises.
  assign phase_end = fall_tick && (edge_cnt == phase_edges(state));

  led_band_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .enable    (busy),
    .clear     (accept),
    .SCLK      (SCLK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Pending flag: any request sets it, acceptance consumes everything seen so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= AUTO_START;
    end else begin
      pending <= request && !accept;
    end
  end

  // State, edge counter and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      LAT      <= 1'b0;
      busy     <= 1'b0;
      fc_sel   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      edge_cnt <= edge_cnt_next;
      LAT      <= lat_next;
      busy     <= busy_next;
      fc_sel   <= fc_sel_next;
      done     <= done_next;
    end
  end

  // Next-state and output decode; rising ticks advance the edge count within a phase.
  always_comb begin
    state_next    = state;
    edge_cnt_next = edge_cnt;
    lat_next      = LAT;
    busy_next     = busy;
    fc_sel_next   = fc_sel;
    done_next     = 1'b0;

    if ((state != IDLE) && rise_tick) begin
      edge_cnt_next = edge_cnt + EDGE_CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_next    = FCWRTEN;
          edge_cnt_next = '0;
          lat_next      = 1'b1;
          busy_next     = 1'b1;
          fc_sel_next   = 1'b1;
        end
      end
      FCWRTEN: begin
        if (phase_end) begin
          state_next    = DATA;
          edge_cnt_next = '0;
          lat_next      = 1'b0;
        end
      end
      DATA: begin
        if (phase_end) begin
          state_next    = WRTFC;
          edge_cnt_next = '0;
          lat_next      = 1'b1;
        end
      end
      WRTFC: begin
        if (phase_end) begin
          state_next    = IDLE;
          edge_cnt_next = '0;
          lat_next      = 1'b0;
          busy_next     = 1'b0;
          fc_sel_next   = 1'b0;
          done_next     = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
